tx_rs_slot_sched: RTL and testbench

- Sequencing controller in front of the RS encoder on the visible-light TX path.
- Pulls bytes from an upstream byte stream and paces them onto fixed baud-dependent slots.
- Cuts the stream into RS codewords of RS_K data slots plus (RS_N-RS_K) check slots, zero-padding the final codeword.
- Generates the sof/data/check/eop strobes the encoder, Manchester coder and header inserter depend on, and enforces an inter-frame gap.

---
 rtl/tx_rs_slot_sched.sv | 156 +++++++++++++++
 tb/tb_tx_rs_slot_sched.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_rs_slot_sched.sv
// tx_rs_slot_sched: paces upstream bytes onto baud slots and frames them into RS codewords
// with data/pad/check strobes and an inter-frame gap.
module tx_rs_slot_sched #(
  parameter int RS_N          = 255,
  parameter int RS_K          = 239,
  parameter int SLOT_PER_FAST = 16,
  parameter int SLOT_PER_SLOW = 192,
  parameter int GAP_SLOTS     = 4
) (
  input  logic       i_vl_tx_clk,
  input  logic       i_vl_tx_rst_n,
  input  logic       i_byte_val,
  input  logic [7:0] i_byte_data,
  input  logic       i_byte_last,
  output logic       o_byte_rdy,
  input  logic       i_rs_en,
  input  logic       i_tx_9600_or_115200,
  output logic       o_sof,
  output logic [7:0] o_data,
  output logic       o_rs_data_symbol,
  output logic       o_rs_check_symbol,
  output logic       o_eop,
  output logic       o_busy,
  output logic       o_underrun
);
  localparam int SMAX = (SLOT_PER_FAST > SLOT_PER_SLOW) ? SLOT_PER_FAST : SLOT_PER_SLOW;
  localparam int SW   = $clog2(SMAX);
  localparam int CW   = $clog2(RS_N + 1);
  localparam int NCHK = RS_N - RS_K;

  typedef enum logic [2:0] {IDLE, DATA, PAD, CHECK, GAP} state_t;

  state_t          st_q, st_d;
  logic [SW-1:0]   slot_q, slot_d;
  logic [CW-1:0]   dcnt_q, dcnt_d, ccnt_q, ccnt_d;
  logic            rate_q, rate_chg, tick;
  logic            last_q, last_d, rs_en_q, rs_en_d;
  logic            sof_q, sof_d, dsym_q, dsym_d, csym_q, csym_d, eop_q, eop_d, und_q, und_d;
  logic [7:0]      data_q, data_d;
  logic            dslot, cw_end;

  // A new rate restarts the slot so the first slow/fast slot is a full period
  assign rate_chg = i_tx_9600_or_115200 != rate_q;
  assign tick     = !rate_chg && slot_q == (rate_q ? SW'(SLOT_PER_FAST - 1) : SW'(SLOT_PER_SLOW - 1));
  assign slot_d   = (rate_chg || tick) ? '0 : slot_q + 1'b1;

  assign o_byte_rdy        = tick && (st_q == IDLE || st_q == DATA) && dcnt_q < CW'(RS_K);
  assign o_busy            = st_q != IDLE;
  assign o_sof             = sof_q;
  assign o_data            = data_q;
  assign o_rs_data_symbol  = dsym_q;
  assign o_rs_check_symbol = csym_q;
  assign o_eop             = eop_q;
  assign o_underrun        = und_q;

  always_comb begin
    st_d    = st_q;
    dcnt_d  = dcnt_q;
    ccnt_d  = ccnt_q;
    last_d  = last_q;
    rs_en_d = rs_en_q;
    data_d  = data_q;
    sof_d   = 1'b0;
    dsym_d  = 1'b0;
    csym_d  = 1'b0;
    eop_d   = 1'b0;
    und_d   = 1'b0;
    dslot   = 1'b0;
    cw_end  = 1'b0;
    if (tick) begin
      unique case (st_q)
        IDLE: if (i_byte_val) begin
          dslot   = 1'b1;
          rs_en_d = i_rs_en;
          data_d  = i_byte_data;
          last_d  = i_byte_last;
        end
        DATA: begin
          dslot  = 1'b1;
          data_d = i_byte_val ? i_byte_data : 8'h00;
          und_d  = !i_byte_val;
          last_d = last_q | (i_byte_val ? i_byte_last : 1'b1);
        end
        PAD: begin
          dslot  = 1'b1;
          data_d = 8'h00;
        end
        CHECK: begin
          csym_d = 1'b1;
          data_d = 8'h00;
          ccnt_d = ccnt_q + 1'b1;
          eop_d  = ccnt_q == CW'(NCHK - 1);
          cw_end = eop_d;
        end
        GAP: begin
          ccnt_d = ccnt_q + 1'b1;
          if (ccnt_q == CW'(GAP_SLOTS - 1)) begin
            st_d   = IDLE;
            ccnt_d = '0;
            last_d = 1'b0;
          end
        end
        default: ;
      endcase
      if (dslot) begin
        dsym_d = 1'b1;
        sof_d  = dcnt_q == '0;
        dcnt_d = dcnt_q + 1'b1;
        st_d   = last_d ? PAD : DATA;
        if (dcnt_d == CW'(RS_K)) begin
          st_d   = rs_en_d ? CHECK : st_d;
          ccnt_d = '0;
          eop_d  = !rs_en_d;
          cw_end = !rs_en_d;
        end
      end
      if (cw_end) begin
        dcnt_d = '0;
        ccnt_d = '0;
        st_d   = last_d ? GAP : DATA;
      end
    end
  end

  always_ff @(posedge i_vl_tx_clk or negedge i_vl_tx_rst_n) begin
    if (!i_vl_tx_rst_n) begin
      st_q    <= IDLE;
      slot_q  <= '0;
      dcnt_q  <= '0;
      ccnt_q  <= '0;
      rate_q  <= 1'b0;
      last_q  <= 1'b0;
      rs_en_q <= 1'b0;
      data_q  <= 8'h00;
      sof_q   <= 1'b0;
      dsym_q  <= 1'b0;
      csym_q  <= 1'b0;
      eop_q   <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      slot_q  <= slot_d;
      dcnt_q  <= dcnt_d;
      ccnt_q  <= ccnt_d;
      rate_q  <= i_tx_9600_or_115200;
      last_q  <= last_d;
      rs_en_q <= rs_en_d;
      data_q  <= data_d;
      sof_q   <= sof_d;
      dsym_q  <= dsym_d;
      csym_q  <= csym_d;
      eop_q   <= eop_d;
      und_q   <= und_d;
    end
  end
endmodule

// File: tb/tb_tx_rs_slot_sched.sv
// tb_tx_rs_slot_sched: directed frames against hand-derived slot sequences, gap length,
// underrun, rate switch timing and mid-frame reset.
module tb_tx_rs_slot_sched;
  localparam int RS_N = 20, RS_K = 16, FAST = 4, SLOW = 12, GAP = 4;

  logic       clk = 1'b0, rst_n = 1'b0, val = 1'b0, last = 1'b0, rs_en = 1'b1, rate = 1'b1;
  logic [7:0] bdata = 8'h00;
  logic       rdy, sof, dsym, csym, eop, busy, und;
  logic [7:0] odata;
  int         total = 0, bad = 0, cyc = 0, und_n = 0, und_t = 0, fall_t = 0;
  logic       busy_p = 1'b0;

  typedef struct { logic s, d, c, e; logic [7:0] v; int t; } rec_t;
  rec_t recs[$], exp_q[$];

  tx_rs_slot_sched #(.RS_N(RS_N), .RS_K(RS_K), .SLOT_PER_FAST(FAST), .SLOT_PER_SLOW(SLOW),
                     .GAP_SLOTS(GAP)) dut (
    .i_vl_tx_clk(clk), .i_vl_tx_rst_n(rst_n), .i_byte_val(val), .i_byte_data(bdata),
    .i_byte_last(last), .o_byte_rdy(rdy), .i_rs_en(rs_en), .i_tx_9600_or_115200(rate),
    .o_sof(sof), .o_data(odata), .o_rs_data_symbol(dsym), .o_rs_check_symbol(csym),
    .o_eop(eop), .o_busy(busy), .o_underrun(und));

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Slot recorder, sampled mid-cycle
  initial forever begin
    @(negedge clk);
    if (sof | dsym | csym | eop) recs.push_back('{sof, dsym, csym, eop, odata, cyc});
    if (und) begin
      und_n++;
      und_t = cyc;
    end
    if (busy_p && !busy) fall_t = cyc;
    busy_p = busy;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // One codeword: nb bytes counting up from first, pads to RS_K, optional checks, eop on last
  function automatic void exp_cw(int nb, logic [7:0] first, logic chk);
    for (int i = 0; i < RS_K; i++)
      exp_q.push_back('{i == 0, 1'b1, 1'b0, 1'b0, (i < nb) ? first + 8'(i) : 8'h00, 0});
    if (chk) for (int i = 0; i < RS_N - RS_K; i++) exp_q.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0});
    exp_q[exp_q.size() - 1].e = 1'b1;
  endfunction

  task automatic send(input int n, input logic [7:0] first, input logic lst);
    int budget;
    for (int i = 0; i < n; i++) begin
      val = 1'b1;
      bdata = first + 8'(i);
      last = lst && (i == n - 1);
      budget = 0;
      do begin
        @(negedge clk);
        budget++;
      end while (!rdy && budget < 2000);
      total++;
      if (!rdy) begin
        bad++;
        $display("FAIL send_rdy byte %0d got rdy=0 want 1", i);
        break;
      end
      @(posedge clk);
      #1;
    end
    val = 1'b0;
    last = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int lim);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy && k < lim);
    total++;
    if (busy) begin
      bad++;
      $display("FAIL %s_idle got busy=1 want 0 after %0d cycles", nm, lim);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++;
    if ({sof, dsym, csym, eop, busy, und, rdy, odata} !== 15'h0) begin
      bad++;
      $display("FAIL reset_outputs got %h want 0", {sof, dsym, csym, eop, busy, und, rdy, odata});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy got %b want 0", busy);
    end
  endtask

  task automatic test_frame(input string nm, input int nb, input logic [7:0] first, input logic en,
                            input logic lst);
    recs.delete();
    exp_q.delete();
    und_n = 0;
    rs_en = en;
    for (int k = 0; k < nb; k += RS_K) exp_cw((nb - k < RS_K) ? nb - k : RS_K, first + 8'(k), en);
    send(nb, first, lst);
    rs_en = ~en;
    wait_idle(nm, 3000);
    total++;
    if (recs.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL %s_count got %0d want %0d", nm, recs.size(), exp_q.size());
    end
    for (int i = 0; i < recs.size() && i < exp_q.size(); i++) begin
      total++;
      if ({recs[i].s, recs[i].d, recs[i].c, recs[i].e, recs[i].v} !==
          {exp_q[i].s, exp_q[i].d, exp_q[i].c, exp_q[i].e, exp_q[i].v}) begin
        bad++;
        $display("FAIL %s_slot%0d got sof%b dat%b chk%b eop%b %h want sof%b dat%b chk%b eop%b %h", nm, i,
                 recs[i].s, recs[i].d, recs[i].c, recs[i].e, recs[i].v,
                 exp_q[i].s, exp_q[i].d, exp_q[i].c, exp_q[i].e, exp_q[i].v);
      end
      if (i > 0) begin
        total++;
        if (recs[i].t - recs[i-1].t != FAST) begin
          bad++;
          $display("FAIL %s_space%0d got %0d want %0d", nm, i, recs[i].t - recs[i-1].t, FAST);
        end
      end
    end
    total++;
    if (fall_t - recs[recs.size() - 1].t != GAP * FAST) begin
      bad++;
      $display("FAIL %s_gap got %0d want %0d", nm, fall_t - recs[recs.size() - 1].t, GAP * FAST);
    end
    total++;
    if (und_n !== (lst ? 0 : 1)) begin
      bad++;
      $display("FAIL %s_underrun_n got %0d want %0d", nm, und_n, lst ? 0 : 1);
    end
    if (!lst) begin
      total++;
      if (und_t !== recs[nb].t) begin
        bad++;
        $display("FAIL %s_underrun_t got %0d want %0d", nm, und_t, recs[nb].t);
      end
    end
    rs_en = en;
  endtask

  task automatic test_rate_switch;
    int sw = 0, k = 0, want;
    recs.delete();
    exp_q.delete();
    rs_en = 1'b1;
    exp_cw(16, 8'h51, 1'b1);
    fork
      send(16, 8'h51, 1'b1);
      begin
        while (recs.size() < 5 && k < 1000) begin
          @(negedge clk);
          k++;
        end
        @(posedge clk);
        #1 rate = 1'b0;
        sw = cyc;
      end
    join
    wait_idle("rate", 5000);
    total++;
    if (recs.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL rate_count got %0d want %0d", recs.size(), exp_q.size());
    end
    for (int i = 0; i < recs.size() && i < exp_q.size(); i++) begin
      total++;
      if ({recs[i].s, recs[i].d, recs[i].c, recs[i].e, recs[i].v} !==
          {exp_q[i].s, exp_q[i].d, exp_q[i].c, exp_q[i].e, exp_q[i].v}) begin
        bad++;
        $display("FAIL rate_slot%0d got %h want %h", i,
                 {recs[i].s, recs[i].d, recs[i].c, recs[i].e, recs[i].v},
                 {exp_q[i].s, exp_q[i].d, exp_q[i].c, exp_q[i].e, exp_q[i].v});
      end
      if (i > 0) begin
        want = (i == 5) ? sw + 13 : recs[i-1].t + ((i < 5) ? FAST : SLOW);
        total++;
        if (recs[i].t != want) begin
          bad++;
          $display("FAIL rate_time%0d got cycle %0d want %0d", i, recs[i].t, want);
        end
      end
    end
    total++;
    if (fall_t - recs[recs.size() - 1].t != GAP * SLOW) begin
      bad++;
      $display("FAIL rate_gap got %0d want %0d", fall_t - recs[recs.size() - 1].t, GAP * SLOW);
    end
    rate = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_mid_check;
    int k = 0, n, eops = 0;
    recs.delete();
    rs_en = 1'b1;
    send(16, 8'h61, 1'b1);
    while (!(recs.size() > 0 && recs[recs.size() - 1].c) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL midrst_busy_before got %b want 1", busy);
    end
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({sof, dsym, csym, eop, busy, und, rdy, odata} !== 15'h0) begin
      bad++;
      $display("FAIL midrst_outputs got %h want 0", {sof, dsym, csym, eop, busy, und, rdy, odata});
    end
    n = recs.size();
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    foreach (recs[i]) eops += int'(recs[i].e);
    total++;
    if (recs.size() !== n) begin
      bad++;
      $display("FAIL midrst_slots got %0d want %0d", recs.size(), n);
    end
    total++;
    if (eops !== 0) begin
      bad++;
      $display("FAIL midrst_eop got %0d want 0", eops);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL midrst_busy_after got %b want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_frame("full16", 16, 8'h01, 1'b1, 1'b1);
    test_frame("short5", 5, 8'h21, 1'b1, 1'b1);
    test_frame("two_cw20", 20, 8'h01, 1'b1, 1'b1);
    test_frame("norsen3", 3, 8'h31, 1'b0, 1'b1);
    test_frame("underrun7", 7, 8'h41, 1'b1, 1'b0);
    test_rate_switch();
    test_reset_mid_check();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
